// File: rtl/srmem_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a shift-register memory bank.
// One producer holds the grant per burst until the memory reports the burst consumed.
module srmem_wr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_BW   = 8,
  parameter int MAX_BEATS = 8,
  parameter int SRC_BW    = $clog2(NUM_SRC),
  parameter int CNT_BW    = $clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*DATA_BW-1:0] src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       mem_valid_din,
  output logic [DATA_BW-1:0]         mem_din,
  output logic                       mem_is_lastdin,
  input  logic                       mem_wrfull,
  input  logic                       mem_wrend,
  output logic                       grant_valid,
  output logic [SRC_BW-1:0]          grant_id,
  output logic [CNT_BW-1:0]          beat_cnt,
  output logic                       err_trunc
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SRC_BW-1:0]   rr_ptr;
  logic [SRC_BW-1:0]   pick_id;
  logic                pick_found;
  logic [SRC_BW:0]     cand;
  logic                cur_valid;
  logic                cur_last;
  logic [DATA_BW-1:0]  cur_data;
  logic                last_beat;
  logic                accept;

  // Search from rr_ptr+1 upward with explicit wrap so non-power-of-2 NUM_SRC works.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr} + (SRC_BW+1)'(i);
      if (cand >= (SRC_BW+1)'(NUM_SRC)) begin
        cand = cand - (SRC_BW+1)'(NUM_SRC);
      end
      if (!pick_found && src_valid[cand[SRC_BW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[SRC_BW-1:0];
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == SRC_BW'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[i*DATA_BW +: DATA_BW];
      end
    end
  end

  // A burst reaching memory capacity is closed even if the source did not mark it last.
  assign last_beat = cur_last | (beat_cnt == CNT_BW'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    src_ready      = '0;
    mem_valid_din  = 1'b0;
    mem_din        = '0;
    mem_is_lastdin = 1'b0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = BURST;
        end
      end
      BURST: begin
        src_ready[grant_id] = ~mem_wrfull;
        mem_valid_din       = cur_valid & ~mem_wrfull;
        mem_din             = cur_data;
        mem_is_lastdin      = last_beat;
        accept              = cur_valid & ~mem_wrfull;
        if (accept && last_beat) begin
          state_next = WAIT_END;
        end
      end
      WAIT_END: begin
        if (mem_wrend) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // rr_ptr moves only when the burst is consumed, so the served source drops to lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      err_trunc   <= 1'b0;
      rr_ptr      <= SRC_BW'(NUM_SRC - 1);
    end else begin
      err_trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_BW'(1);
            if (last_beat) begin
              err_trunc <= ~cur_last;
            end
          end
        end
        WAIT_END: begin
          if (mem_wrend) begin
            rr_ptr      <= grant_id;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srmem_wr_arbiter.sv
// Directed self-checking bench for srmem_wr_arbiter (NUM_SRC=4, DATA_BW=8, MAX_BEATS=8).
module tb_srmem_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  src_ready;
  logic        mem_valid_din;
  logic [7:0]  mem_din;
  logic        mem_is_lastdin;
  logic        mem_wrfull;
  logic        mem_wrend;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [3:0]  beat_cnt;
  logic        err_trunc;

  int tests_run;
  int tests_failed;

  srmem_wr_arbiter #(.NUM_SRC(4), .DATA_BW(8), .MAX_BEATS(8)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .mem_valid_din(mem_valid_din), .mem_din(mem_din), .mem_is_lastdin(mem_is_lastdin),
    .mem_wrfull(mem_wrfull), .mem_wrend(mem_wrend),
    .grant_valid(grant_valid), .grant_id(grant_id), .beat_cnt(beat_cnt), .err_trunc(err_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0; src_last = '0; src_data = '0;
    mem_wrfull = 1'b0; mem_wrend = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_wrend();
    mem_wrend = 1'b1;
    tick();
    mem_wrend = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_grant_valid got=%0b exp=0", grant_valid); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_grant_id got=%0d exp=0", grant_id); end
    tests_run++; if (beat_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    tests_run++; if (err_trunc !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_trunc got=%0b exp=0", err_trunc); end
    tests_run++; if (src_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_src_ready got=%b exp=0000", src_ready); end
    tests_run++; if (mem_valid_din !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_valid got=%0b exp=0", mem_valid_din); end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_d;
    src_valid = 4'b0100;
    src_data[16 +: 8] = 8'hA0;
    src_last = '0;
    #1;
    tests_run++; if (grant_valid !== 1'b0 || src_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_no_grant_same_cycle got gv=%0b rdy=%b exp gv=0 rdy=0000", grant_valid, src_ready); end
    tick();
    tests_run++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL single_grant got gv=%0b id=%0d exp gv=1 id=2", grant_valid, grant_id); end
    for (int k = 0; k < 3; k++) begin
      exp_d = 8'hA0 + 8'(k);
      src_data[16 +: 8] = exp_d;
      src_last[2] = (k == 2);
      #1;
      tests_run++; if (mem_valid_din !== 1'b1 || mem_din !== exp_d) begin tests_failed++; $display("[TB] FAIL single_beat%0d got v=%0b d=%0h exp v=1 d=%0h", k, mem_valid_din, mem_din, exp_d); end
      tests_run++; if (mem_is_lastdin !== (k == 2) || src_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_last%0d got last=%0b rdy=%b exp last=%0b rdy=0100", k, mem_is_lastdin, src_ready, (k == 2)); end
      tick();
    end
    src_valid = '0; src_last = '0;
    #1;
    tests_run++; if (beat_cnt !== 4'd3) begin tests_failed++; $display("[TB] FAIL single_beat_cnt got=%0d exp=3", beat_cnt); end
    tests_run++; if (src_ready !== 4'b0000 || mem_valid_din !== 1'b0 || grant_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_wait_end got rdy=%b v=%0b gv=%0b exp rdy=0000 v=0 gv=1", src_ready, mem_valid_din, grant_valid); end
    tick();
    tests_run++; if (grant_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_hold_wait got gv=%0b exp=1", grant_valid); end
    pulse_wrend();
    tests_run++; if (grant_valid !== 1'b0 || beat_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL single_to_idle got gv=%0b cnt=%0d exp gv=0 cnt=0", grant_valid, beat_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset();
    src_valid = 4'hF; src_last = 4'hF;
    for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int n = 0; n < 5; n++) begin
      exp_id = 2'(n % 4);
      tick();
      tests_run++; if (grant_id !== exp_id || mem_din !== (8'h10 + 8'(exp_id))) begin tests_failed++; $display("[TB] FAIL rr_grant%0d got id=%0d d=%0h exp id=%0d d=%0h", n, grant_id, mem_din, exp_id, 8'h10 + 8'(exp_id)); end
      tick();
      pulse_wrend();
    end
    src_valid = '0; src_last = '0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    src_valid = 4'b0010;
    src_last = '0;
    tick();
    tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL bp_grant got=%0d exp=1", grant_id); end
    for (int k = 0; k < 2; k++) begin
      exp_d = 8'h50 + 8'(k);
      src_data[8 +: 8] = exp_d;
      #1;
      tests_run++; if (mem_valid_din !== 1'b1 || mem_din !== exp_d) begin tests_failed++; $display("[TB] FAIL bp_pre%0d got v=%0b d=%0h exp v=1 d=%0h", k, mem_valid_din, mem_din, exp_d); end
      tick();
    end
    mem_wrfull = 1'b1;
    src_data[8 +: 8] = 8'h52;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++; if (src_ready !== 4'b0000 || mem_valid_din !== 1'b0 || beat_cnt !== 4'd2) begin tests_failed++; $display("[TB] FAIL bp_stall%0d got rdy=%b v=%0b cnt=%0d exp rdy=0000 v=0 cnt=2", c, src_ready, mem_valid_din, beat_cnt); end
      tick();
    end
    mem_wrfull = 1'b0;
    for (int k = 2; k < 4; k++) begin
      exp_d = 8'h50 + 8'(k);
      src_data[8 +: 8] = exp_d;
      src_last[1] = (k == 3);
      #1;
      tests_run++; if (mem_din !== exp_d || beat_cnt !== 4'(k) || src_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL bp_post%0d got d=%0h cnt=%0d rdy=%b exp d=%0h cnt=%0d rdy=0010", k, mem_din, beat_cnt, src_ready, exp_d, k); end
      tick();
    end
    tests_run++; if (beat_cnt !== 4'd4) begin tests_failed++; $display("[TB] FAIL bp_total got=%0d exp=4", beat_cnt); end
    src_valid = '0; src_last = '0;
    pulse_wrend();
  endtask

  task automatic test_truncation();
    logic [7:0] exp_d;
    src_valid = 4'b0001;
    src_last = '0;
    tick();
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL trunc_grant got=%0d exp=0", grant_id); end
    for (int k = 0; k < 8; k++) begin
      exp_d = 8'h80 + 8'(k);
      src_data[0 +: 8] = exp_d;
      #1;
      tests_run++; if (mem_valid_din !== 1'b1 || mem_din !== exp_d || mem_is_lastdin !== (k == 7)) begin tests_failed++; $display("[TB] FAIL trunc_beat%0d got v=%0b d=%0h last=%0b exp v=1 d=%0h last=%0b", k, mem_valid_din, mem_din, mem_is_lastdin, exp_d, (k == 7)); end
      tick();
    end
    src_data[0 +: 8] = 8'h88;
    #1;
    tests_run++; if (err_trunc !== 1'b1 || beat_cnt !== 4'd8 || mem_valid_din !== 1'b0) begin tests_failed++; $display("[TB] FAIL trunc_pulse got err=%0b cnt=%0d v=%0b exp err=1 cnt=8 v=0", err_trunc, beat_cnt, mem_valid_din); end
    tick();
    tests_run++; if (err_trunc !== 1'b0) begin tests_failed++; $display("[TB] FAIL trunc_pulse_width got=%0b exp=0", err_trunc); end
    pulse_wrend();
    tick();
    tests_run++; if (grant_id !== 2'd0 || grant_valid !== 1'b1 || beat_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL trunc_regrant got id=%0d gv=%0b cnt=%0d exp id=0 gv=1 cnt=0", grant_id, grant_valid, beat_cnt); end
    for (int k = 8; k < 10; k++) begin
      exp_d = 8'h80 + 8'(k);
      src_data[0 +: 8] = exp_d;
      src_last[0] = (k == 9);
      #1;
      tests_run++; if (mem_din !== exp_d || mem_is_lastdin !== (k == 9)) begin tests_failed++; $display("[TB] FAIL trunc_rest%0d got d=%0h last=%0b exp d=%0h last=%0b", k, mem_din, mem_is_lastdin, exp_d, (k == 9)); end
      tick();
    end
    tests_run++; if (err_trunc !== 1'b0 || beat_cnt !== 4'd2) begin tests_failed++; $display("[TB] FAIL trunc_natural_end got err=%0b cnt=%0d exp err=0 cnt=2", err_trunc, beat_cnt); end
    src_valid = '0; src_last = '0;
    pulse_wrend();
  endtask

  task automatic test_reset_mid_burst();
    src_valid = 4'b0100;
    src_last = '0;
    tick();
    tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL rstmid_grant got=%0d exp=2", grant_id); end
    for (int k = 0; k < 2; k++) begin
      src_data[16 +: 8] = 8'hC0 + 8'(k);
      tick();
    end
    tests_run++; if (beat_cnt !== 4'd2) begin tests_failed++; $display("[TB] FAIL rstmid_cnt got=%0d exp=2", beat_cnt); end
    rst = 1'b1;
    tick();
    tests_run++; if (grant_valid !== 1'b0 || src_ready !== 4'b0000 || mem_valid_din !== 1'b0 || beat_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL rstmid_idle got gv=%0b rdy=%b v=%0b cnt=%0d exp gv=0 rdy=0000 v=0 cnt=0", grant_valid, src_ready, mem_valid_din, beat_cnt); end
    rst = 1'b0;
    src_valid = 4'hF;
    tick();
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL rstmid_rr_restart got=%0d exp=0", grant_id); end
    src_last = 4'hF;
    tick();
    pulse_wrend();
    src_valid = '0; src_last = '0;
  endtask

  task automatic test_wrend_in_burst();
    src_valid = 4'b1000;
    src_last = '0;
    src_data[24 +: 8] = 8'hE0;
    mem_wrend = 1'b1;
    tick();
    tests_run++; if (grant_id !== 2'd3 || grant_valid !== 1'b1 || mem_valid_din !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrend_grant got id=%0d gv=%0b v=%0b exp id=3 gv=1 v=1", grant_id, grant_valid, mem_valid_din); end
    tick();
    tests_run++; if (grant_valid !== 1'b1 || beat_cnt !== 4'd1 || src_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL wrend_ignored got gv=%0b cnt=%0d rdy=%b exp gv=1 cnt=1 rdy=1000", grant_valid, beat_cnt, src_ready); end
    mem_wrend = 1'b0;
    src_data[24 +: 8] = 8'hE1;
    src_last[3] = 1'b1;
    #1;
    tests_run++; if (mem_din !== 8'hE1 || mem_is_lastdin !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrend_last_beat got d=%0h last=%0b exp d=e1 last=1", mem_din, mem_is_lastdin); end
    tick();
    src_valid = '0; src_last = '0;
    tick();
    tests_run++; if (grant_valid !== 1'b1 || src_ready !== 4'b0000 || beat_cnt !== 4'd2) begin tests_failed++; $display("[TB] FAIL wrend_waits got gv=%0b rdy=%b cnt=%0d exp gv=1 rdy=0000 cnt=2", grant_valid, src_ready, beat_cnt); end
    pulse_wrend();
    tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrend_release got gv=%0b exp=0", grant_valid); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    src_valid = '0; src_data = '0; src_last = '0;
    mem_wrfull = 1'b0; mem_wrend = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid_burst();
    test_wrend_in_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
